// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Shared types and helpers for the sequential restoring divider.
//               - div_state_t : FSM state encoding (IDLE, CALC, DONE)
//               - cnt_width() : iteration counter width for an N-bit divider
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter must index iterations 0..N-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : divider_pkg
`default_nettype wire

// File: rtl/prefix_sub.sv
`default_nettype none
// ============================================================================
// Module      : prefix_sub
// Description : Combinational W-bit subtractor diff = a + ~b + 1 whose carry
//               chain is a Kogge-Stone parallel-prefix tree with cin = 1.
// Ports       : a, b       - W-bit unsigned operands
//               diff       - a - b modulo 2^W
//               no_borrow  - final carry out, 1 iff a >= b
// Revision    : 1.0 - initial release
// ============================================================================
module prefix_sub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         no_borrow
);

    localparam int STAGES = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0] w_bn;
    logic [W-1:0] w_p;
    logic [W-1:0] w_g;
    logic [W-1:0] w_grp_g;
    logic [W-1:0] w_grp_p;

    assign w_bn = ~b;
    assign w_p  = a ^ w_bn;
    assign w_g  = a & w_bn;

    // Group generate over [i:0] including the carry-in. Bits are updated from
    // the top down inside each stage so every bit combines with the lower
    // neighbour's value from the previous stage.
    always_comb begin
        w_grp_g    = w_g;
        w_grp_p    = w_p;
        // cin = 1 folds into bit 0: carry out of bit 0 is g0 | p0.
        w_grp_g[0] = w_g[0] | w_p[0];
        for (int s = 0; s < STAGES; s++) begin
            for (int i = W - 1; i >= (1 << s); i--) begin
                w_grp_g[i] = w_grp_g[i] | (w_grp_p[i] & w_grp_g[i - (1 << s)]);
                w_grp_p[i] = w_grp_p[i] & w_grp_p[i - (1 << s)];
            end
        end
    end

    assign diff      = w_p ^ {w_grp_g[W-2:0], 1'b1};
    assign no_borrow = w_grp_g[W-1];

endmodule : prefix_sub
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle unsigned radix-2 restoring divider, one quotient
//               bit per cycle, valid/ready handshakes on operands and result.
// Ports       : clk, rst_n (async, active low)
//               in_valid/in_ready, dividend, divisor        - operand side
//               out_valid/out_ready, quotient, remainder,
//               div_by_zero                                 - result side
//               busy                                        - CALC or DONE
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import divider_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy
);

    localparam int            CW     = cnt_width(N);
    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    div_state_t    r_state;
    div_state_t    w_next;
    logic [CW-1:0] r_cnt;
    logic [N:0]    r_r;        // partial remainder
    logic [N-1:0]  r_q;        // quotient being assembled
    logic [N-1:0]  r_d;        // working dividend, MSB feeds R each step
    logic [N-1:0]  r_divisor;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rem;
    logic          r_dbz;
    logic          r_out_valid;

    logic          w_accept;
    logic          w_div_zero;
    logic [N:0]    w_rsh;
    logic [N:0]    w_diff;
    logic          w_no_borrow;
    logic          w_unused_r_msb;

    assign w_accept       = in_valid && (r_state == IDLE);
    assign w_div_zero     = (divisor == '0);
    assign w_rsh          = {r_r[N-1:0], r_d[N-1]};
    // A restoring step never leaves R[N] set, so the top bit is not consumed.
    assign w_unused_r_msb = r_r[N];

    prefix_sub #(
        .W (N + 1)
    ) u_sub (
        .a         (w_rsh),
        .b         ({1'b0, r_divisor}),
        .diff      (w_diff),
        .no_borrow (w_no_borrow)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next = w_div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy = 1'b1;
                if (r_out_valid && out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_divisor   <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_d       <= dividend;
                        r_divisor <= divisor;
                        r_r       <= '0;
                        r_q       <= '0;
                        r_cnt     <= '0;
                        // Divide-by-zero skips CALC and presents its result
                        // on the very next cycle.
                        if (w_div_zero) begin
                            r_quot      <= '1;
                            r_rem       <= dividend;
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_r   <= w_no_borrow ? w_diff : w_rsh;
                    r_q   <= {r_q[N-2:0], w_no_borrow};
                    r_d   <= {r_d[N-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    // First DONE cycle registers the result; afterwards hold
                    // until the consumer takes it.
                    if (!r_out_valid) begin
                        r_quot      <= r_q;
                        r_rem       <= r_r[N-1:0];
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_dbz       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule : seq_divider
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle unsigned radix-2 restoring divider. It is the inverse of the prefix adder datapath: each step does one trial subtraction on a parallel-prefix subtract stage. The block sits beside the adder as a shared arithmetic unit, with valid/ready handshakes on both the operand side and the result side. One operation is in flight at a time.

Parameters:
N, 32, operand width in bits for dividend, divisor, quotient and remainder (N >= 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands (high only in IDLE)
dividend  input  N  unsigned dividend, sampled on the in_valid&in_ready edge
divisor  input  N  unsigned divisor, sampled on the same edge
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  N  unsigned quotient
remainder  output  N  unsigned remainder
div_by_zero  output  1  set with out_valid when divisor was 0
busy  output  1  high in CALC or DONE

Behaviour:
- Reset:
  - Asynchronous on rst_n low; the state goes to IDLE.
  - in_ready is 1; out_valid, busy, div_by_zero are 0.
  - quotient and remainder are 0; the iteration counter is 0.
  - A reset mid-operation aborts the operation; no result is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch the operands and clear the partial remainder R (N+1 bits) and the quotient register Q.
  - Divisor != 0: go to CALC with count=0.
  - Divisor == 0: go to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
- CALC, one iteration per cycle, N cycles total:
  - R_sh = {R[N-1:0], D[N-1]}, where D is the working dividend shifted left 1 per iteration.
  - T = R_sh - {1'b0,divisor}, computed (N+1)-bit wide.
  - If there is no borrow (R_sh >= divisor): R=T and the new quotient LSB is 1. Otherwise R=R_sh and the new quotient LSB is 0.
  - Q shifts left, taking the new LSB.
  - When count==N-1, go to DONE.
- DONE:
  - out_valid=1; quotient=Q; remainder=R[N-1:0]; div_by_zero as latched.
  - All outputs are held stable while out_valid&!out_ready.
  - On out_valid&out_ready, go to IDLE; clear div_by_zero and out_valid. quotient and remainder hold their last values.
- Latency:
  - Nonzero divisor: out_valid rises N+1 edges after the accept edge (N CALC cycles, then the DONE register).
  - Zero divisor: out_valid rises 1 edge after the accept edge.
- Throughput: in_ready returns 1 in the cycle after the result handshake. There is no same-cycle result-out/operand-in overlap.
- in_valid while not in IDLE is ignored; the operands are not sampled.
- The (N+1)-bit R guarantees correct results when the divisor MSB is 1. R[N] is always 0 after each iteration.
- Operands changing after the accept edge have no effect.

Decomposition:
- Package divider_pkg holds:
  - the typedef enum logic [1:0] div_state_t {IDLE, CALC, DONE};
  - a localparam function for the counter width, $clog2(N).
- Sub-module prefix_sub #(W):
  - Combinational (N+1)-bit subtractor, diff = a + ~b + 1.
  - The carry network is a log2(W)-stage parallel-prefix generate/propagate tree with cin=1.
  - Outputs are diff[W-1:0] and no_borrow (the final carry out, 1 iff a>=b).
  - Instantiated once, with W=N+1.

Test Plan:
- 100 / 7, out_ready=1 -> out_valid exactly 33 edges after accept; quotient=14, remainder=2, div_by_zero=0.
- 0x12345678 / 0 -> out_valid 1 edge after accept; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- Boundary values:
  - 0xFFFFFFFF / 0x80000000 -> quotient=1, remainder=0x7FFFFFFF.
  - 5 / 0x80000000 -> quotient=0, remainder=5.
  - 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Required: outputs stable and in_ready=0 throughout; in_valid pulses are ignored.
  - After out_ready=1 for one edge, in_ready=1 the next cycle.
- Reset mid-operation: assert rst_n=0 asynchronously at iteration 10 of 50 / 3.
  - Required: immediate in_ready=1, out_valid=0, quotient=remainder=0.
  - A following 9 / 4 then yields quotient=2, remainder=1.
- Random regression: 10k random pairs, including divisor=1, divisor=dividend, dividend<divisor, and N=8.
  - Required: quotient*divisor+remainder==dividend and remainder<divisor.
